// File: rtl/mux_pkg.sv
// Shared constants and helpers for the channel mux / scan blocks.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Explicit wrap, so a non-power-of-two channel count never reaches an invalid index
    function automatic int unsigned sel_next(
        input int unsigned cur,
        input int unsigned ch
    );
        return (cur == ch - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell counter for scan mode; tick marks the last cycle on a channel.
module scan_timer #(
    parameter int DWELL = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_nby1_scan.sv
// N-channel registered mux with manual select and round-robin scan mode.
module mux_nby1_scan
    import mux_pkg::*;
#(
    parameter int CH    = 4,
    parameter int W     = 1,
    parameter int DWELL = 200,
    localparam int SW   = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*W-1:0] d,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    input  logic            hold,
    output logic [W-1:0]    y,
    output logic [SW-1:0]   cur_sel,
    output logic            sw_pulse
);

    localparam int IW = $clog2(CH * W);

    logic          prev_mode;
    logic          mode_entry;
    logic          en;
    logic          clr;
    logic          tick;
    logic          sel_chg;
    logic [SW-1:0] sel_nxt;
    logic [IW-1:0] base;

    assign mode_entry = (mode == MODE_SCAN) && (prev_mode == MODE_MANUAL);
    assign en         = (mode == MODE_SCAN) && !hold;
    // Mode entry clears the counter even while hold is asserted
    assign clr        = mode_entry || ((mode == MODE_MANUAL) && !hold);

    scan_timer #(
        .DWELL(DWELL)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        sel_nxt = cur_sel;
        unique case (1'b1)
            !hold && (mode == MODE_MANUAL): begin
                if (int'(sel) < CH) sel_nxt = sel;
            end
            tick: sel_nxt = SW'(sel_next(int'(cur_sel), CH));
            default: sel_nxt = cur_sel;
        endcase
    end

    assign base = IW'(cur_sel) * IW'(W);

    // The strobe is delayed one cycle so it lines up with the new channel's first y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel   <= '0;
            y         <= '0;
            sel_chg   <= 1'b0;
            sw_pulse  <= 1'b0;
            prev_mode <= MODE_MANUAL;
        end else begin
            cur_sel   <= sel_nxt;
            y         <= d[base +: W];
            sel_chg   <= (sel_nxt != cur_sel);
            sw_pulse  <= sel_chg;
            prev_mode <= mode;
        end
    end

endmodule

// File: tb/tb_mux_nby1_scan.sv
// Bench for mux_nby1_scan: 4-ch and 3-ch instances, scoreboard plus directed checks.
module tb_mux_nby1_scan;

    typedef struct {
        logic [7:0] y;
        logic [1:0] cs;
        logic       sp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] d_a;
    logic [1:0]  sel_a;
    logic        mode_a, hold_a;
    logic [7:0]  y_a;
    logic [1:0]  cs_a;
    logic        sp_a;
    logic [23:0] d_b;
    logic [1:0]  sel_b;
    logic        mode_b, hold_b;
    logic [7:0]  y_b;
    logic [1:0]  cs_b;
    logic        sp_b;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    int   ma_s, ma_c, mb_s, mb_c;
    logic ma_p, ma_g, mb_p, mb_g;

    mux_nby1_scan #(.CH(4), .W(8), .DWELL(5)) u_a (
        .clk(clk), .rst_n(rst_n), .d(d_a), .sel(sel_a), .mode(mode_a),
        .hold(hold_a), .y(y_a), .cur_sel(cs_a), .sw_pulse(sp_a)
    );

    mux_nby1_scan #(.CH(3), .W(8), .DWELL(4)) u_b (
        .clk(clk), .rst_n(rst_n), .d(d_b), .sel(sel_b), .mode(mode_b),
        .hold(hold_b), .y(y_b), .cur_sel(cs_b), .sw_pulse(sp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input int ch, input int dwell, input logic [31:0] d,
                         input int selin, input logic mode, input logic hold,
                         inout int s, inout int c, inout logic p,
                         inout logic g, output exp_t e);
        logic entry, tk;
        int   ns;
        entry = mode && !p;
        tk    = mode && !hold && !entry && (c == dwell - 1);
        e.y   = d[s*8 +: 8];
        e.sp  = g;
        if (hold) ns = s;
        else if (!mode) ns = (selin < ch) ? selin : s;
        else if (tk) ns = (s == ch - 1) ? 0 : s + 1;
        else ns = s;
        if (entry || (!mode && !hold)) c = 0;
        else if (mode && !hold) c = tk ? 0 : c + 1;
        e.cs = 2'(ns);
        g    = (ns != s);
        s    = ns;
        p    = mode;
    endtask

    task automatic model_reset();
        ma_s = 0; ma_c = 0; ma_p = 1'b0; ma_g = 1'b0;
        mb_s = 0; mb_c = 0; mb_p = 1'b0; mb_g = 1'b0;
        q_a.delete();
        q_b.delete();
    endtask

    task automatic cyc();
        exp_t ea, eb;
        model(4, 5, d_a, int'(sel_a), mode_a, hold_a, ma_s, ma_c, ma_p, ma_g, ea);
        q_a.push_back(ea);
        model(3, 4, {8'h00, d_b}, int'(sel_b), mode_b, hold_b,
              mb_s, mb_c, mb_p, mb_g, eb);
        q_b.push_back(eb);
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check("sb_a_y", y_a, ea.y);
        check("sb_a_sel", cs_a, ea.cs);
        check("sb_a_pulse", sp_a, ea.sp);
        check("sb_b_y", y_b, eb.y);
        check("sb_b_sel", cs_b, eb.cs);
        check("sb_b_pulse", sp_b, eb.sp);
    endtask

    initial begin
        int last, last_i, nchg, npulse, maxsel;
        rst_n  = 1'b0;
        d_a    = $urandom;
        d_b    = 24'($urandom);
        sel_a  = 2'd0; mode_a = 1'b0; hold_a = 1'b0;
        sel_b  = 2'd0; mode_b = 1'b0; hold_b = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_y", y_a, 8'h00);
        check("rst_a_sel", cs_a, 2'd0);
        check("rst_a_pulse", sp_a, 1'b0);
        check("rst_b_y", y_b, 8'h00);
        rst_n = 1'b1;

        // manual select on the 4-channel instance
        d_a = 32'h44332211;
        d_b = 24'hCCBBAA;
        cyc();
        check("a_rel_y", y_a, 8'h11);
        sel_a = 2'd2;
        cyc();
        check("a_sel_cs", cs_a, 2'd2);
        check("a_sel_nopulse_yet", sp_a, 1'b0);
        cyc();
        check("a_sel_y", y_a, 8'h33);
        check("a_sel_pulse", sp_a, 1'b1);
        cyc();
        check("a_sel_pulse_once", sp_a, 1'b0);

        // out-of-range select on the 3-channel instance
        sel_b = 2'd1;
        cyc();
        cyc();
        check("b_sel1_y", y_b, 8'hBB);
        sel_b = 2'd3;
        cyc();
        check("b_oor_cs", cs_b, 2'd1);
        check("b_oor_pulse", sp_b, 1'b0);
        cyc();
        check("b_oor_y", y_b, 8'hBB);
        check("b_oor_pulse2", sp_b, 1'b0);

        // scan wrap 0,1,2,0 every 4 cycles
        sel_b = 2'd0;
        cyc();
        cyc();
        check("b_pre_scan", cs_b, 2'd0);
        mode_b = 1'b1;
        last = 0; last_i = 1; nchg = 0; npulse = 0; maxsel = 0;
        for (int i = 1; i <= 14; i++) begin
            cyc();
            if (int'(cs_b) > maxsel) maxsel = int'(cs_b);
            if (sp_b) npulse++;
            if (int'(cs_b) != last) begin
                nchg++;
                check("b_scan_period", i - last_i, 4);
                check("b_scan_next", cs_b, (last == 2) ? 0 : last + 1);
                last   = int'(cs_b);
                last_i = i;
            end
        end
        check("b_scan_changes", nchg, 3);
        check("b_scan_pulses", npulse, 3);
        check("b_scan_max", maxsel, 2);

        // hold at cnt=2 for 10 cycles
        cyc();
        hold_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_b = 24'($urandom);
            cyc();
            check("b_hold_cs", cs_b, 2'd0);
            check("b_hold_y", y_b, d_b[7:0]);
        end
        hold_b = 1'b0;
        cyc();
        check("b_rel_1", cs_b, 2'd0);
        cyc();
        check("b_rel_2", cs_b, 2'd1);

        // mode entry from manual sel=1 with DWELL=5
        sel_a = 2'd1;
        cyc();
        check("a_entry_pre", cs_a, 2'd1);
        mode_a = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            check("a_entry_adv", cs_a, (i == 6) ? 2'd2 : 2'd1);
        end

        // mode entry together with hold: counter still restarts
        mode_b = 1'b0;
        sel_b  = 2'd2;
        cyc();
        mode_b = 1'b1;
        hold_b = 1'b1;
        cyc();
        check("b_entry_hold", cs_b, 2'd2);
        hold_b = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("b_entry_hold_adv", cs_b, (i == 4) ? 2'd0 : 2'd2);
        end

        // asynchronous reset between edges
        cyc();
        cyc();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_a_y", y_a, 8'h00);
        check("arst_a_sel", cs_a, 2'd0);
        check("arst_a_pulse", sp_a, 1'b0);
        check("arst_b_y", y_b, 8'h00);
        check("arst_b_sel", cs_b, 2'd0);
        check("arst_b_pulse", sp_b, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        check("arst_restart_a", cs_a, 2'd0);
        check("arst_restart_b", cs_b, 2'd0);

        // random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            d_a = $urandom;
            d_b = 24'($urandom);
            if ($urandom_range(0, 3) == 0) sel_a = 2'($urandom);
            if ($urandom_range(0, 3) == 0) sel_b = 2'($urandom);
            if ($urandom_range(0, 15) == 0) mode_a = !mode_a;
            if ($urandom_range(0, 15) == 0) mode_b = !mode_b;
            hold_a = ($urandom_range(0, 7) == 0);
            hold_b = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
